// File: rtl/tail_pack.sv
// Instruction packer: one header nibble plus its legal tail nibbles, emitted one
// nibble per cycle on a valid/ready stream. Illegal headers are dropped with an err pulse.
module tail_pack #(
    parameter int NW = 4,
    parameter int TN = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_hdr,
    input  logic [TN*NW-1:0]  in_tail,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NW-1:0]     out_data,
    output logic              out_last,
    output logic              err
);
    localparam int CW = $clog2(TN + 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e            state_q;
    logic [NW-1:0]     data_q;
    logic              last_q;
    logic              err_q;
    logic [CW-1:0]     cnt_q;
    logic [TN*NW-1:0]  tail_q;

    logic              accept;
    logic              out_hs;
    logic              hdr_ok;
    logic [CW-1:0]     hdr_cnt;

    function automatic logic hdr_legal(input logic [3:0] h);
        casez (h)
            4'b??00, 4'b1?0?, 4'b0001, 4'b0010, 4'b0011: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    // Number of tail nibbles that follow the header (total length minus one).
    function automatic logic [CW-1:0] hdr_tail_cnt(input logic [3:0] h);
        case (h)
            4'b0001: return CW'(1);
            4'b0010: return CW'(3);
            4'b0011: return CW'(7);
            default: return '0;
        endcase
    endfunction

    function automatic logic [TN*NW-1:0] keep_tail(input logic [TN*NW-1:0] t,
                                                   input logic [CW-1:0]    n);
        logic [TN*NW-1:0] r;
        r = '0;
        for (int k = 0; k < TN; k++) begin
            if (k < int'(n)) r[NW*k +: NW] = t[NW*k +: NW];
        end
        return r;
    endfunction

    assign out_valid = (state_q == SEND);
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign err       = err_q;

    // A finishing packet frees the slot in the same cycle, so packets chain without a bubble.
    assign in_ready  = !out_valid || (out_ready && last_q);
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign hdr_ok    = hdr_legal(in_hdr);
    assign hdr_cnt   = hdr_tail_cnt(in_hdr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                if (hdr_ok) begin
                    state_q <= SEND;
                    data_q  <= NW'(in_hdr);
                    last_q  <= (hdr_cnt == '0);
                    cnt_q   <= hdr_cnt;
                end else begin
                    state_q <= IDLE;
                    last_q  <= 1'b0;
                    err_q   <= 1'b1;
                end
            end else if (out_hs) begin
                if (last_q) begin
                    state_q <= IDLE;
                    last_q  <= 1'b0;
                end else begin
                    data_q  <= tail_q[NW-1:0];
                    cnt_q   <= cnt_q - CW'(1);
                    last_q  <= (cnt_q == CW'(1));
                end
            end
        end
    end

    // Tail shift register: pure datapath, only meaningful while cnt_q says so.
    always_ff @(posedge clk) begin
        if (accept && hdr_ok) begin
            tail_q <= keep_tail(in_tail, hdr_cnt);
        end else if (out_hs && !last_q) begin
            tail_q <= tail_q >> NW;
        end
    end
endmodule

// File: tb/tb_tail_pack.sv
// Randomized and directed bench for tail_pack against a table-driven packet model.
module tb_tail_pack;
    localparam int NW    = 4;
    localparam int TN    = 7;
    localparam int TAILW = TN * NW;
    localparam logic [TAILW-1:0] TCONST = 28'h7654321;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_hdr;
    logic [TAILW-1:0] in_tail;
    logic             out_valid;
    logic             out_ready;
    logic [NW-1:0]    out_data;
    logic             out_last;
    logic             err;

    int checks = 0;
    int errors = 0;

    // Total nibbles per header value, 0 = illegal.
    int LEN [16] = '{1, 2, 4, 8, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

    logic [NW-1:0] exp_nib [$];
    logic [NW-1:0] obs_nib [$];
    logic          obs_last [$];
    int obs_err, obs_err_first, obs_first_valid, obs_held, obs_extra, obs_timeout;

    always #5 clk = ~clk;

    tail_pack #(.NW(NW), .TN(TN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr), .in_tail(in_tail),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_pkt(input logic [3:0] h, input logic [TAILW-1:0] t);
        int l;
        l = LEN[h];
        exp_nib.delete();
        if (l > 0) begin
            exp_nib.push_back(NW'(h));
            for (int k = 0; k < l - 1; k++) exp_nib.push_back(t[NW*k +: NW]);
        end
    endtask

    // Offers one packet from idle and records what comes out; no judgement here.
    task automatic send_pkt(input logic [3:0] hdr, input logic [TAILW-1:0] tail, input bit rand_rdy);
        logic [NW-1:0] prev_d;
        logic          prev_l;
        bit            stalled, done, quiet;
        obs_nib.delete();
        obs_last.delete();
        obs_err = 0; obs_err_first = 0; obs_first_valid = -1;
        obs_held = 0; obs_extra = 0; obs_timeout = 0;
        stalled = 0; done = 0; quiet = 0; prev_d = '0; prev_l = 1'b0;
        in_valid = 1'b1; in_hdr = hdr; in_tail = tail; out_ready = 1'b1;
        tick;
        in_valid = 1'b0; in_hdr = 4'($urandom); in_tail = TAILW'($urandom);
        for (int c = 1; c <= 40 && !done && !quiet; c++) begin
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (err) begin
                obs_err++;
                if (c == 1) obs_err_first = 1;
            end
            if (out_valid) begin
                if (obs_first_valid < 0) obs_first_valid = c;
                if (stalled && (out_data !== prev_d || out_last !== prev_l)) obs_held++;
                stalled = !out_ready; prev_d = out_data; prev_l = out_last;
                if (out_ready) begin
                    obs_nib.push_back(out_data);
                    obs_last.push_back(out_last);
                    if (out_last) done = 1;
                end
            end else if (c >= 3) begin
                quiet = 1;
            end
            tick;
        end
        if (!done && !quiet) obs_timeout = 1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (out_valid) obs_extra++;
            if (err) obs_err++;
            tick;
        end
    endtask

    task automatic test_reset;
        int busy;
        rst = 1'b1; in_valid = 1'b0; in_hdr = '0; in_tail = '0; out_ready = 1'b1;
        tick;
        tick;
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b e=%b l=%b d=%h want v=0 e=0 l=0 d=0",
                     out_valid, err, out_last, out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        busy = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (out_valid !== 1'b0 || err !== 1'b0) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL idle_quiet: got %0d active cycles want 0", busy);
        end
    endtask

    task automatic test_all_headers;
        for (int h = 0; h < 16; h++) begin
            model_pkt(4'(h), TCONST);
            send_pkt(4'(h), TCONST, 1'b0);
            checks++;
            if (obs_nib.size() != exp_nib.size()) begin
                errors++;
                $display("FAIL hdr%0h_len: got %0d nibbles want %0d", h, obs_nib.size(), exp_nib.size());
            end else begin
                for (int i = 0; i < exp_nib.size(); i++) begin
                    checks++;
                    if (obs_nib[i] !== exp_nib[i] || obs_last[i] !== 1'(i == exp_nib.size() - 1)) begin
                        errors++;
                        $display("FAIL hdr%0h_nib%0d: got d=%h l=%b want d=%h l=%b", h, i,
                                 obs_nib[i], obs_last[i], exp_nib[i], (i == exp_nib.size() - 1));
                    end
                end
            end
            checks++;
            if (obs_err != ((LEN[h] == 0) ? 1 : 0) || obs_err_first != ((LEN[h] == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL hdr%0h_err: got %0d pulses (first=%0d) want %0d", h, obs_err,
                         obs_err_first, (LEN[h] == 0) ? 1 : 0);
            end
            checks++;
            if (obs_first_valid != ((LEN[h] == 0) ? -1 : 1)) begin
                errors++;
                $display("FAIL hdr%0h_latency: got %0d want %0d", h, obs_first_valid,
                         (LEN[h] == 0) ? -1 : 1);
            end
            checks++;
            if (obs_held + obs_extra + obs_timeout != 0) begin
                errors++;
                $display("FAIL hdr%0h_protocol: got held=%0d extra=%0d timeout=%0d want 0 0 0", h,
                         obs_held, obs_extra, obs_timeout);
            end
        end
    endtask

    task automatic test_backpressure;
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int ptr;
        model_pkt(4'b0010, TCONST);
        ptr = 0;
        in_valid = 1'b1; in_hdr = 4'b0010; in_tail = TCONST; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            out_ready = 1'(pat[c-1]);
            #1;
            checks++;
            if (ptr >= exp_nib.size() || out_valid !== 1'b1 || out_data !== exp_nib[ptr] ||
                out_last !== 1'(ptr == exp_nib.size() - 1)) begin
                errors++;
                $display("FAIL bp_data_c%0d: got v=%b d=%h l=%b want v=1 nibble index %0d", c,
                         out_valid, out_data, out_last, ptr);
            end
            checks++;
            if (in_ready !== 1'(out_ready && ptr == exp_nib.size() - 1)) begin
                errors++;
                $display("FAIL bp_in_ready_c%0d: got %b want %b", c, in_ready,
                         (out_ready && ptr == exp_nib.size() - 1));
            end
            if (out_ready) ptr++;
            tick;
        end
        checks++;
        if (out_valid !== 1'b0 || ptr != exp_nib.size()) begin
            errors++;
            $display("FAIL bp_end: got v=%b consumed=%0d want v=0 consumed=%0d", out_valid, ptr,
                     exp_nib.size());
        end
        out_ready = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [NW-1:0] seq [$];
        int  ends [2];
        bit  acc;
        model_pkt(4'b0011, TCONST);
        seq = exp_nib;
        ends[0] = exp_nib.size();
        model_pkt(4'b0001, TCONST);
        foreach (exp_nib[i]) seq.push_back(exp_nib[i]);
        ends[1] = seq.size();
        out_ready = 1'b1;
        in_valid = 1'b1; in_hdr = 4'b0011; in_tail = TCONST;
        tick;
        in_hdr = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (c <= seq.size()) begin
                if (out_valid !== 1'b1 || out_data !== seq[c-1] ||
                    out_last !== 1'(c == ends[0] || c == ends[1])) begin
                    errors++;
                    $display("FAIL b2b_c%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", c, out_valid,
                             out_data, out_last, seq[c-1], (c == ends[0] || c == ends[1]));
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_c%0d: got v=%b want v=0", c, out_valid);
            end
            acc = in_valid && in_ready;
            tick;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int busy;
        model_pkt(4'b0011, TCONST);
        out_ready = 1'b1;
        in_valid = 1'b1; in_hdr = 4'b0011; in_tail = TCONST;
        tick;
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_nib[c-1]) begin
                errors++;
                $display("FAIL rstmid_pre_c%0d: got v=%b d=%h want v=1 d=%h", c, out_valid,
                         out_data, exp_nib[c-1]);
            end
            if (c == 3) rst = 1'b1;
            tick;
        end
        rst = 1'b0;
        busy = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid !== 1'b0 || err !== 1'b0) busy++;
            tick;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL rstmid_abort: got %0d active cycles want 0", busy);
        end
        model_pkt(4'b0001, TCONST);
        send_pkt(4'b0001, TCONST, 1'b0);
        checks++;
        if (obs_nib.size() != 2 || obs_nib[0] !== exp_nib[0] || obs_nib[1] !== exp_nib[1] ||
            obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1 || obs_err != 0) begin
            errors++;
            $display("FAIL rstmid_after: got %0d nibbles err=%0d want 2 nibbles %h,%h err=0",
                     obs_nib.size(), obs_err, exp_nib[0], exp_nib[1]);
        end
    endtask

    task automatic test_illegal_then_legal;
        out_ready = 1'b1;
        in_valid = 1'b1; in_hdr = 4'b1111; in_tail = TCONST;
        tick;
        in_hdr = 4'b0000;
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ill_c1: got err=%b v=%b want err=1 v=0", err, out_valid);
        end
        tick;
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b0 || out_valid !== 1'b1 || out_data !== '0 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL ill_c2: got err=%b v=%b d=%h l=%b want err=0 v=1 d=0 l=1", err,
                     out_valid, out_data, out_last);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL ill_c3: got v=%b err=%b want v=0 err=0", out_valid, err);
        end
    endtask

    task automatic test_random;
        logic [3:0]       h;
        logic [TAILW-1:0] t;
        for (int n = 0; n < 30; n++) begin
            h = 4'($urandom);
            t = TAILW'($urandom);
            model_pkt(h, t);
            send_pkt(h, t, 1'b1);
            checks++;
            if (obs_nib.size() != exp_nib.size()) begin
                errors++;
                $display("FAIL rnd%0d_len hdr=%h: got %0d want %0d", n, h, obs_nib.size(), exp_nib.size());
            end else begin
                for (int i = 0; i < exp_nib.size(); i++) begin
                    checks++;
                    if (obs_nib[i] !== exp_nib[i] || obs_last[i] !== 1'(i == exp_nib.size() - 1)) begin
                        errors++;
                        $display("FAIL rnd%0d_nib%0d hdr=%h: got d=%h l=%b want d=%h l=%b", n, i, h,
                                 obs_nib[i], obs_last[i], exp_nib[i], (i == exp_nib.size() - 1));
                    end
                end
            end
            checks++;
            if (obs_err != ((LEN[h] == 0) ? 1 : 0) || obs_held + obs_extra + obs_timeout != 0) begin
                errors++;
                $display("FAIL rnd%0d_ctrl hdr=%h: got err=%0d held=%0d extra=%0d timeout=%0d want err=%0d others 0",
                         n, h, obs_err, obs_held, obs_extra, obs_timeout, (LEN[h] == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_all_headers;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_illegal_then_legal;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/tail_pack.md
Name: tail_pack

Overview:
- Packer/serializer for the variable-length instruction stream. It is the transmit side of the header-nibble length encoding.
- Accepts one instruction per handshake: a 4-bit header plus up to 7 tail nibbles.
- Classifies the header into a total length of 1, 2, 4 or 8 nibbles, or illegal.
- Emits the header nibble, then the tail nibbles, one nibble per cycle on a valid/ready stream into the instruction memory/fetch path.

Parameters:
- NW, 4, nibble width in bits. The spec is written for 4; the header is always 4 bits.
- TN, 7, tail nibble capacity. in_tail is TN*NW bits.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  block can take an instruction this cycle
- in_hdr  in  4  header nibble
- in_tail  in  TN*NW  tail payload; nibble k is in_tail[NW*k +: NW], emitted k-th after the header
- out_valid  out  1  out_data holds a valid nibble
- out_ready  in  1  sink takes the nibble
- out_data  out  NW  current nibble
- out_last  out  1  out_data is the final nibble of the instruction
- err  out  1  one-cycle pulse: illegal header dropped

Behaviour:
- Single clock, clk. rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, err=0, remaining count=0, state IDLE.
- Reset asserted mid-instruction aborts it: no further nibbles, and the partial packet is not completed.
- Header length decode (L = total nibbles including header):
  - ??00 -> 1
  - 1?0? -> 1
  - 0001 -> 2
  - 0010 -> 4
  - 0011 -> 8
  - all others are illegal: 0101, 0110, 0111, 1010, 1011, 1110, 1111
  - 0101 and 0110 are defined illegal here, not don't-care.
- States: IDLE (out_valid=0) and SEND (out_valid=1).
- in_ready = !out_valid | (out_ready & out_last). This is combinational from registered state and out_ready, and allows back-to-back packets with no bubble.
- Accept = in_valid & in_ready.
- Accept with a legal header:
  - Next cycle: out_valid=1, out_data=in_hdr, out_last=(L==1).
  - The first L-1 tail nibbles are loaded into a shift register; remaining count = L-1.
  - Latency from accept to first nibble is 1 cycle.
- Accept with an illegal header:
  - Nothing is emitted; err=1 for exactly the next cycle.
  - If a packet was finishing on the same edge, out_valid goes 0 next cycle.
  - Tail is ignored.
- In SEND:
  - out_valid & out_ready & !out_last: shift to the next tail nibble, decrement count, and set out_last when count reaches 1.
  - out_valid & !out_ready: out_data and out_last hold stable (standard stream rule).
  - On the final handshake with no new accept, go to IDLE with out_valid=0 and out_data holding its last value.
  - On the final handshake with a same-cycle legal accept, the new header appears the next cycle.
- Unused tail nibbles (index >= L-1) are ignored and never emitted.
- Throughput: one nibble per cycle when out_ready is held high. An L=8 packet occupies 8 output cycles.
- in_valid may drop without being accepted: nothing happens. The input side has no stability requirement toward this block.
- No internal queue beyond the one packet in flight.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, err=0, in_ready=1. Hold in_valid=0 for 10 cycles -> no outputs.
- All 16 headers, tail=0x7654321, out_ready=1:
  - 0000 and 1101 -> single nibble with out_last=1.
  - 0001 -> 1,1.
  - 0010 -> 2,1,2,3.
  - 0011 -> 3,1,2,3,4,5,6,7.
  - 7 illegal codes -> err pulse of 1 cycle each, out_valid stays 0.
- Back-pressure: send 0010 and toggle out_ready 1,0,0,1,0,1,1 -> out_data is held while stalled, the sequence is exactly 2,1,2,3, and in_ready stays 0 until the last handshake.
- Back-to-back: in_valid held with 0011 then 0001, out_ready=1 -> 10 consecutive valid cycles, no bubble, out_last on cycles 8 and 10.
- Reset mid-packet: rst for one cycle during nibble 3 of an 0011 packet -> out_valid=0 next cycle, no remaining nibbles. A subsequent 0001 packet emits cleanly.
- Illegal then legal: 1111 then 0000 on consecutive accepts -> err on cycle 1, single-nibble packet 0 on cycle 2.
